// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: datapath widths, fetch FSM encoding,
// instruction-queue entry layout and PC alignment helper.
package mips_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc_plus4;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order instruction queue; entry 0 is always the head.
// Flush wins over push and pop; push while full is only honoured with a pop.
module fetch_queue
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] push_instr_i,
  input  logic [XLEN-1:0]    push_pc4_i,
  output logic [1:0]         count_o,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [XLEN-1:0]    head_pc4_o
);

  fq_entry_t  e0_q, e0_d, e1_q, e1_d, new_s;
  logic [1:0] cnt_q, cnt_d;
  logic       push_ok_s, pop_ok_s;

  // Next-state for entries and occupancy.
  always_comb begin
    e0_d      = e0_q;
    e1_d      = e1_q;
    cnt_d     = cnt_q;
    new_s     = '{instr: push_instr_i, pc_plus4: push_pc4_i};
    pop_ok_s  = pop_i & (cnt_q != 2'd0);
    push_ok_s = push_i & ((cnt_q != 2'd2) | pop_ok_s);
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            e0_d = new_s;
          end else begin
            e1_d = new_s;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the older entry moves to the head first.
          if (cnt_q == 2'd1) begin
            e0_d = new_s;
          end else begin
            e0_d = e1_q;
            e1_d = new_s;
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // Queue storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o      = cnt_q;
  assign head_instr_o = e0_q.instr;
  assign head_pc4_o   = e0_q.pc_plus4;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem read at a time feeding a
// 2-entry queue; redirects flush the queue and drain any in-flight response.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [XLEN-1:0]    id_pc_plus4
);

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d;
  logic            req_q, req_d;
  logic [1:0]      q_count_s, occ_next_s;
  logic            q_push_s, q_pop_s, ack_acc_s, pend_keep_s, issue_s;
  logic [XLEN-1:0] pc_adv_s;

  fetch_queue u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (q_push_s),
    .pop_i        (q_pop_s),
    .flush_i      (redirect_valid),
    .push_instr_i (imem_rdata),
    .push_pc4_i   (pc_adv_s),
    .count_o      (q_count_s),
    .head_instr_o (id_instr),
    .head_pc4_o   (id_pc_plus4)
  );

  assign id_valid  = (q_count_s != 2'd0);
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign pc_adv_s  = pc_q + 32'd4;

  // Request, PC and FSM next-state; pc_q is the address of the current or next fetch.
  always_comb begin
    ack_acc_s   = req_q & imem_ack;
    pend_keep_s = req_q & ~imem_ack;
    q_pop_s     = id_valid & ~stall & ~redirect_valid;
    q_push_s    = ack_acc_s & (state_q == ST_FETCH) & ~redirect_valid;

    if (redirect_valid) begin
      occ_next_s = 2'd0;
      pc_d       = align_pc(redirect_pc);
    end else begin
      occ_next_s = q_count_s + {1'b0, q_push_s} - {1'b0, q_pop_s};
      pc_d       = q_push_s ? pc_adv_s : pc_q;
    end

    // A new request is only launched when its response is guaranteed a slot.
    issue_s = ~pend_keep_s & (occ_next_s < 2'd2);
    req_d   = pend_keep_s | issue_s;
    if (issue_s) begin
      addr_d = pc_d;
    end else begin
      addr_d = addr_q;
    end

    case (state_q)
      ST_FETCH: begin
        if (redirect_valid && pend_keep_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (ack_acc_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Fetch control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall back-pressure, redirects,
// reset mid-request, and PC wrap on a second instance.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic        stall, redirect_valid, man_ack, inst_ack;
  logic [31:0] redirect_pc;

  logic        imem_req, imem_ack, id_valid;
  logic [31:0] imem_addr, imem_rdata, id_instr, id_pc_plus4;

  logic        imem_req2, imem_ack2, id_valid2;
  logic [31:0] imem_addr2, imem_rdata2, id_instr2, id_pc_plus42;
  logic        zero_b;
  logic [31:0] zero_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign imem_ack    = inst_ack ? imem_req : man_ack;
  assign imem_rdata  = f(imem_addr);
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = f(imem_addr2);
  assign zero_b      = 1'b0;
  assign zero_w      = 32'h0000_0000;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst2_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .stall(zero_b),
    .redirect_valid(zero_b), .redirect_pc(zero_w),
    .id_valid(id_valid2), .id_instr(id_instr2), .id_pc_plus4(id_pc_plus42)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    rst_n = 1'b1; rst2_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0000_0000; man_ack = 1'b0; inst_ack = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", imem_req, 32'd0);
    chk("rst_valid", id_valid, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pc4", id_pc_plus4, 32'd0);
    tick; tick;
    chk("rst_hold_req", imem_req, 32'd0);
    rst_n = 1'b1;
    tick;

    // Sequential fetch, ack one cycle after each request.
    for (int i = 0; i < 3; i++) begin
      a = 32'(i) << 2;
      chk("seq_req", imem_req, 32'd1);
      chk("seq_addr", imem_addr, a);
      tick;
      chk("seq_hold_addr", imem_addr, a);
      chk("seq_idv0", id_valid, 32'd0);
      man_ack = 1'b1;
      tick;
      man_ack = 1'b0;
      chk("seq_idv1", id_valid, 32'd1);
      chk("seq_instr", id_instr, f(a));
      chk("seq_pc4", id_pc_plus4, a + 32'd4);
      chk("seq_next_addr", imem_addr, a + 32'd4);
    end

    // Stall with instant acks: queue fills, request drops, head holds.
    stall = 1'b1; inst_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_req", imem_req, 32'd0);
      chk("stall_idv", id_valid, 32'd1);
      chk("stall_instr", id_instr, f(32'h0000_0008));
      chk("stall_pc4", id_pc_plus4, 32'h0000_000C);
    end
    stall = 1'b0;
    tick;
    chk("rel_instr0", id_instr, f(32'h0000_000C));
    chk("rel_pc4_0", id_pc_plus4, 32'h0000_0010);
    chk("rel_req", imem_req, 32'd1);
    chk("rel_addr0", imem_addr, 32'h0000_0010);
    tick;
    chk("rel_instr1", id_instr, f(32'h0000_0010));
    chk("rel_pc4_1", id_pc_plus4, 32'h0000_0014);
    chk("rel_addr1", imem_addr, 32'h0000_0014);

    // Redirect while a request is pending and the queue holds an entry.
    inst_ack = 1'b0; stall = 1'b1;
    tick;
    chk("pre_rd_idv", id_valid, 32'd1);
    chk("pre_rd_instr", id_instr, f(32'h0000_0010));
    chk("pre_rd_addr", imem_addr, 32'h0000_0014);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick;
    redirect_valid = 1'b0; stall = 1'b0;
    chk("drain_idv", id_valid, 32'd0);
    chk("drain_req", imem_req, 32'd1);
    chk("drain_old_addr", imem_addr, 32'h0000_0014);
    man_ack = 1'b1;
    tick;
    man_ack = 1'b0;
    chk("drain_discard_idv", id_valid, 32'd0);
    chk("drain_req2", imem_req, 32'd1);
    chk("drain_new_addr", imem_addr, 32'h0000_0100);
    tick;
    chk("tgt_idv0", id_valid, 32'd0);
    man_ack = 1'b1;
    tick;
    man_ack = 1'b0;
    chk("tgt_instr", id_instr, f(32'h0000_0100));
    chk("tgt_pc4", id_pc_plus4, 32'h0000_0104);
    chk("tgt_next_addr", imem_addr, 32'h0000_0104);

    // Redirect coincident with ack: that response must never reach decode.
    man_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick;
    man_ack = 1'b0; redirect_valid = 1'b0;
    chk("coin_idv", id_valid, 32'd0);
    chk("coin_req", imem_req, 32'd1);
    chk("coin_addr", imem_addr, 32'h0000_0200);
    man_ack = 1'b1;
    tick;
    man_ack = 1'b0;
    chk("coin_instr", id_instr, f(32'h0000_0200));
    chk("coin_pc4", id_pc_plus4, 32'h0000_0204);

    // Fill the queue, release, then reset in the middle of a request.
    stall = 1'b1; man_ack = 1'b1;
    tick;
    man_ack = 1'b0;
    chk("full_req", imem_req, 32'd0);
    chk("full_instr", id_instr, f(32'h0000_0200));
    stall = 1'b0;
    tick;
    chk("full_order_instr", id_instr, f(32'h0000_0204));
    chk("full_order_pc4", id_pc_plus4, 32'h0000_0208);
    chk("full_order_addr", imem_addr, 32'h0000_0208);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 32'd0);
    chk("mid_rst_idv", id_valid, 32'd0);
    chk("mid_rst_instr", id_instr, 32'd0);
    chk("mid_rst_pc4", id_pc_plus4, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("refetch_req", imem_req, 32'd1);
    chk("refetch_addr", imem_addr, 32'h0000_0000);
    chk("refetch_idv", id_valid, 32'd0);

    // PC wrap on the instance reset to FFFF_FFF8, instant acks.
    rst2_n = 1'b1;
    tick;
    chk("wrap_req", imem_req2, 32'd1);
    chk("wrap_addr0", imem_addr2, 32'hFFFF_FFF8);
    chk("wrap_idv0", id_valid2, 32'd0);
    tick;
    chk("wrap_addr1", imem_addr2, 32'hFFFF_FFFC);
    chk("wrap_instr1", id_instr2, f(32'hFFFF_FFF8));
    chk("wrap_pc4_1", id_pc_plus42, 32'hFFFF_FFFC);
    tick;
    chk("wrap_addr2", imem_addr2, 32'h0000_0000);
    chk("wrap_instr2", id_instr2, f(32'hFFFF_FFFC));
    chk("wrap_pc4_2", id_pc_plus42, 32'h0000_0000);
    tick;
    chk("wrap_addr3", imem_addr2, 32'h0000_0004);
    chk("wrap_pc4_3", id_pc_plus42, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
